// File: rtl/gbf_pkg.sv
// Shared types and helpers for the GBF burst channel.
//   gbf_state_e : channel FSM states
//   gbf_base()  : tile base address from (i,j,k) for input or weight layout
//   AW, ID_W    : address / id widths for the default channel configuration
package gbf_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain
    } gbf_state_e;

    localparam int unsigned AW   = $clog2(96);
    localparam int unsigned ID_W = $clog2(4) + 1;

    // mode 0 (input):  (i*minor_dim + k) * burst_len
    // mode 1 (weight): (k*minor_dim + j) * burst_len
    // Computed at 32 bits so callers can range-check before truncating.
    function automatic logic [31:0] gbf_base(input logic        mode,
                                             input logic [31:0] i,
                                             input logic [31:0] j,
                                             input logic [31:0] k,
                                             input logic [31:0] minor_dim,
                                             input logic [31:0] burst_len);
        logic [31:0] tile;
        tile = mode ? (k * minor_dim + j) : (i * minor_dim + k);
        return tile * burst_len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above rr_ptr_i,
// wrapping to the lowest asserted request otherwise.
//   req_i       : request vector
//   rr_ptr_i    : search start position
//   winner_o    : one-hot grant of the winner (0 when no request)
//   winner_id_o : binary index of the winner
//   any_o       : at least one request asserted
module rr_arbiter
    import gbf_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = ID_W
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] rr_ptr_i,
    output logic [N-1:0] winner_o,
    output logic [W-1:0] winner_id_o,
    output logic         any_o
);

    logic         hi_found;
    logic         lo_found;
    logic [W-1:0] hi_id;
    logic [W-1:0] lo_id;

    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_found = 1'b1;
                lo_id    = W'(i);
                if (i >= int'(rr_ptr_i)) begin
                    hi_found = 1'b1;
                    hi_id    = W'(i);
                end
            end
        end
    end

    assign any_o       = lo_found;
    assign winner_id_o = hi_found ? hi_id : lo_id;

    always_comb begin
        winner_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            winner_o[i] = any_o && (winner_id_o == W'(i));
        end
    end

endmodule

// File: rtl/gbf_burst_channel.sv
// GBF read-bus channel: NUM_REQ requesters share one RAM read port. A round-robin
// winner holds its grant for a whole BURST_LEN-word tile read starting at a base
// derived from its (i,j,k) index; read data returns RAM_LAT cycles later tagged
// with id / valid / last.
//   clk, rst (async, active-low)
//   req, idx_i/j/k        : requester side (indices packed per requester)
//   grant                 : one-hot, first address through last data
//   ram_en/ram_addr/ram_q : RAM read port
//   data_out/vld/last/id  : returned data to the PEs
//   busy, err             : channel not idle / out-of-range burst pulse
module gbf_burst_channel
    import gbf_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned HEIGHT    = 96,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned MINOR_DIM = 3,
    parameter int unsigned MODE      = 0,
    parameter int unsigned RAM_LAT   = 1,
    localparam int unsigned AddrW    = $clog2(HEIGHT),
    localparam int unsigned IdW      = $clog2(NUM_REQ) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] idx_i,
    input  logic [NUM_REQ*IDX_W-1:0] idx_j,
    input  logic [NUM_REQ*IDX_W-1:0] idx_k,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     ram_en,
    output logic [AddrW-1:0]         ram_addr,
    input  logic [WIDTH-1:0]         ram_q,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_vld,
    output logic                     data_last,
    output logic [IdW-1:0]           data_id,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned BeatW = $clog2(BURST_LEN + 1);

    gbf_state_e state_q, state_d;

    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]     win_id_q, win_id_d;
    logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
    logic [AddrW-1:0]   base_q, base_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IdW-1:0]     arb_id;
    logic               arb_any;

    logic [IDX_W-1:0]   sel_i, sel_j, sel_k;
    logic [31:0]        base_full;
    logic [32:0]        end_addr;
    logic               in_range;
    logic               beat_last;

    logic [RAM_LAT-1:0] vld_q;
    logic [RAM_LAT-1:0] last_q;
    logic [IdW-1:0]     id_q [RAM_LAT];

    function automatic logic [IdW-1:0] ptr_after(input logic [IdW-1:0] id);
        return (id == IdW'(NUM_REQ - 1)) ? '0 : id + IdW'(1);
    endfunction

    rr_arbiter #(
        .N (NUM_REQ),
        .W (IdW)
    ) u_arb (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (arb_oh),
        .winner_id_o (arb_id),
        .any_o       (arb_any)
    );

    // Index of the current arbitration winner.
    always_comb begin
        sel_i = '0;
        sel_j = '0;
        sel_k = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (arb_oh[r]) begin
                sel_i = idx_i[r*IDX_W +: IDX_W];
                sel_j = idx_j[r*IDX_W +: IDX_W];
                sel_k = idx_k[r*IDX_W +: IDX_W];
            end
        end
    end

    // Range check is done on the untruncated base.
    assign base_full = gbf_base(MODE != 0, 32'(sel_i), 32'(sel_j), 32'(sel_k),
                                32'(MINOR_DIM), 32'(BURST_LEN));
    assign end_addr  = {1'b0, base_full} + 33'(BURST_LEN);
    assign in_range  = end_addr <= 33'(HEIGHT);
    assign beat_last = beat_q == BeatW'(BURST_LEN - 1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            win_id_q <= '0;
            win_oh_q <= '0;
            base_q   <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_id_q <= win_id_d;
            win_oh_q <= win_oh_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_id_d = win_id_q;
        win_oh_d = win_oh_q;
        base_d   = base_q;
        beat_d   = beat_q;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    if (!in_range) begin
                        // Skip the offender so the next requester gets a turn.
                        err_d    = 1'b1;
                        rr_ptr_d = ptr_after(arb_id);
                    end else begin
                        state_d  = StBurst;
                        win_id_d = arb_id;
                        win_oh_d = arb_oh;
                        base_d   = base_full[AddrW-1:0];
                        beat_d   = '0;
                    end
                end
            end
            StBurst: begin
                beat_d = beat_q + BeatW'(1);
                if (beat_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (data_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = ptr_after(win_id_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        ram_en   = 1'b0;
        ram_addr = '0;
        grant    = '0;
        busy     = 1'b0;
        unique case (state_q)
            StBurst: begin
                ram_en   = 1'b1;
                ram_addr = base_q + AddrW'(beat_q);
                grant    = win_oh_q;
                busy     = 1'b1;
            end
            StDrain: begin
                grant = win_oh_q;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

    assign err = err_q;

    // Read-return pipeline, aligned with the RAM latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int s = 0; s < int'(RAM_LAT); s++) begin
                id_q[s] <= '0;
            end
        end else begin
            vld_q[0]  <= ram_en;
            last_q[0] <= ram_en && beat_last;
            id_q[0]   <= win_id_q;
            for (int s = 1; s < int'(RAM_LAT); s++) begin
                vld_q[s]  <= vld_q[s-1];
                last_q[s] <= last_q[s-1];
                id_q[s]   <= id_q[s-1];
            end
        end
    end

    assign data_vld  = vld_q[RAM_LAT-1];
    assign data_last = data_vld && last_q[RAM_LAT-1];
    assign data_id   = data_vld ? id_q[RAM_LAT-1] : '0;
    assign data_out  = data_vld ? ram_q : '0;

endmodule
